// File: rtl/qubit_pair_scheduler_if.sv
// Control handshake plus amplitude-RAM strobe/address bundle for qubit_pair_scheduler.
// The err pulse exists only when QPS_TARGET_CHECK_EN is defined.
interface qubit_pair_scheduler_if #(
  parameter int AW = 3,
  parameter int TW = 2
);
  logic          start;
  logic [TW-1:0] target;
  logic          busy;
  logic          done;
`ifdef QPS_TARGET_CHECK_EN
  logic          err;
`endif
  logic          rd_en;
  logic [AW-1:0] rd_addr0;
  logic [AW-1:0] rd_addr1;
  logic          wr_en;
  logic [AW-1:0] wr_addr0;
  logic [AW-1:0] wr_addr1;

  // master is the scheduler; slave is the QFT control plus the RAM/gate side
`ifdef QPS_TARGET_CHECK_EN
  modport master (
    input  start, target,
    output busy, done, err,
    output rd_en, rd_addr0, rd_addr1,
    output wr_en, wr_addr0, wr_addr1
  );
  modport slave (
    output start, target,
    input  busy, done, err,
    input  rd_en, rd_addr0, rd_addr1,
    input  wr_en, wr_addr0, wr_addr1
  );
`else
  modport master (
    input  start, target,
    output busy, done,
    output rd_en, rd_addr0, rd_addr1,
    output wr_en, wr_addr0, wr_addr1
  );
  modport slave (
    output start, target,
    input  busy, done,
    input  rd_en, rd_addr0, rd_addr1,
    input  wr_en, wr_addr0, wr_addr1
  );
`endif
endinterface

// File: rtl/qubit_pair_scheduler.sv
// Walks every amplitude pair (i, i | 1<<t) once per pass: reads both, writes gate results back L cycles later.
// Optional feature macro QPS_TARGET_CHECK_EN: reject out-of-range targets with an err pulse instead of wrapping.
module qubit_pair_scheduler #(
  parameter int N_QUBITS = 3,
  parameter int MEM_LAT  = 1,
  parameter int GATE_LAT = 1,
  parameter int AW       = N_QUBITS,
  parameter int TW       = (N_QUBITS > 1) ? $clog2(N_QUBITS) : 1
) (
  input logic                    clk,
  input logic                    rst_n,
  qubit_pair_scheduler_if.master bus
);
  localparam int L = MEM_LAT + GATE_LAT;
  localparam logic [AW-1:0] NUM_PAIRS = AW'(1 << (N_QUBITS - 1));
  // Every write-delay stage except the output one
  localparam logic [L-1:0] UPPER_MASK = ~(L'(1) << (L - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] target_q, target_d;
  logic [AW-1:0] p_q, p_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] rd_addr0_q, rd_addr0_d;
  logic [AW-1:0] rd_addr1_q, rd_addr1_d;

  logic [L-1:0]         dl_valid_q, dl_valid_d;
  logic [L-1:0][AW-1:0] dl_addr0_q, dl_addr0_d;
  logic [L-1:0][AW-1:0] dl_addr1_q, dl_addr1_d;

  logic          target_ok;
  logic [TW-1:0] t_in;
  logic          issue;
  logic [AW-1:0] issue_p;
  logic [TW-1:0] issue_t;
  logic [AW-1:0] issue_idx0;
  logic          drain_pending;

`ifdef QPS_TARGET_CHECK_EN
  logic err_q, err_d;
  assign target_ok = (32'(bus.target) < N_QUBITS);
  assign t_in      = bus.target;
`else
  assign target_ok = 1'b1;
  assign t_in      = TW'(32'(bus.target) % N_QUBITS);
`endif

  // Insert a 0 bit at position t of the pair counter
  function automatic logic [AW-1:0] pair_idx0(input logic [AW-1:0] p, input logic [TW-1:0] t);
    logic [AW-1:0] low_mask;
    low_mask = (AW'(1) << t) - AW'(1);
    return ((p & ~low_mask) << 1) | (p & low_mask);
  endfunction

  assign drain_pending = rd_en_q | (|(dl_valid_q & UPPER_MASK));
  assign issue_idx0    = pair_idx0(issue_p, issue_t);

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    p_d        = p_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    issue_p    = p_q;
    issue_t    = target_q;
`ifdef QPS_TARGET_CHECK_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start && target_ok) begin
          target_d = t_in;
          issue    = 1'b1;
          issue_p  = '0;
          issue_t  = t_in;
          p_d      = AW'(1);
          busy_d   = 1'b1;
          state_d  = S_ISSUE;
        end
`ifdef QPS_TARGET_CHECK_EN
        err_d = bus.start && !target_ok;
`endif
      end
      S_ISSUE: begin
        if (p_q == NUM_PAIRS) begin
          state_d = S_DRAIN;
        end else begin
          issue = 1'b1;
          p_d   = p_q + AW'(1);
        end
      end
      S_DRAIN: begin
        // Finish once the last write-back is on the bus this cycle
        if (!drain_pending) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rd_en_d    = issue;
    rd_addr0_d = issue ? issue_idx0 : '0;
    rd_addr1_d = issue ? (issue_idx0 | (AW'(1) << issue_t)) : '0;
  end

  assign dl_valid_d[0] = rd_en_q;
  assign dl_addr0_d[0] = rd_addr0_q;
  assign dl_addr1_d[0] = rd_addr1_q;

  for (genvar gi = 1; gi < L; gi++) begin : g_delay
    assign dl_valid_d[gi] = dl_valid_q[gi-1];
    assign dl_addr0_d[gi] = dl_addr0_q[gi-1];
    assign dl_addr1_d[gi] = dl_addr1_q[gi-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      p_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr0_q <= '0;
      rd_addr1_q <= '0;
      dl_valid_q <= '0;
      dl_addr0_q <= '0;
      dl_addr1_q <= '0;
`ifdef QPS_TARGET_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      p_q        <= p_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_addr0_q <= rd_addr0_d;
      rd_addr1_q <= rd_addr1_d;
      dl_valid_q <= dl_valid_d;
      dl_addr0_q <= dl_addr0_d;
      dl_addr1_q <= dl_addr1_d;
`ifdef QPS_TARGET_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr0 = rd_addr0_q;
  assign bus.rd_addr1 = rd_addr1_q;
  assign bus.wr_en    = dl_valid_q[L-1];
  assign bus.wr_addr0 = dl_addr0_q[L-1];
  assign bus.wr_addr1 = dl_addr1_q[L-1];
`ifdef QPS_TARGET_CHECK_EN
  assign bus.err      = err_q;
`endif

endmodule
